// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub
//   Two-stage pipelined adder/subtractor built on a two-level carry-lookahead
//   tree (4-bit groups, lookahead across the group carries). Valid/ready
//   handshake on both sides, with full-rate streaming and lossless stalls.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset (clears valid bits and data)
//   in_valid   operand beat present
//   in_ready   block accepts the operand beat this cycle
//   a, b       operands (unsigned or two's complement)
//   cin        carry-in, used in add mode only
//   sub        0 = a + b + cin, 1 = a - b (a + ~b + 1)
//   out_valid  result beat present
//   out_ready  downstream accepts the result beat
//   sum        result
//   cout       carry out of the MSB (subtract: 1 = no borrow)
//   ovf        signed two's-complement overflow
//   zero       sum == 0
module pipelined_cla_addsub #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG = WIDTH / GROUP;

    generate
        if (GROUP != 4) begin : g_bad_group
            $error("pipelined_cla_addsub: GROUP must be 4");
        end
        if (WIDTH < 4 || WIDTH > 64 || (WIDTH % GROUP) != 0) begin : g_bad_width
            $error("pipelined_cla_addsub: WIDTH must be a multiple of GROUP in 4..64");
        end
    endgenerate

    // ---- stage 0: operand conditioning, bit and group generate/propagate ----
    logic [WIDTH-1:0] beff_p0, g_p0, p_p0, lc_p0;
    logic             ceff_p0;
    logic [NG-1:0]    gg_p0, gp_p0;

    always_comb begin
        beff_p0 = sub ? ~b : b;
        ceff_p0 = sub ? 1'b1 : cin;
        g_p0    = a & beff_p0;
        p_p0    = a ^ beff_p0;
        lc_p0   = '0;
        gg_p0   = '0;
        gp_p0   = '0;
        for (int k = 0; k < NG; k++) begin
            // Local carries assume a zero carry into the group; the real
            // group carry is folded in after the pipeline register.
            lc_p0[k*GROUP+1] = g_p0[k*GROUP];
            lc_p0[k*GROUP+2] = g_p0[k*GROUP+1] | (p_p0[k*GROUP+1] & g_p0[k*GROUP]);
            lc_p0[k*GROUP+3] = g_p0[k*GROUP+2] | (p_p0[k*GROUP+2] & g_p0[k*GROUP+1])
                             | (p_p0[k*GROUP+2] & p_p0[k*GROUP+1] & g_p0[k*GROUP]);
            gg_p0[k] = g_p0[k*GROUP+3]
                     | (p_p0[k*GROUP+3] & g_p0[k*GROUP+2])
                     | (p_p0[k*GROUP+3] & p_p0[k*GROUP+2] & g_p0[k*GROUP+1])
                     | (p_p0[k*GROUP+3] & p_p0[k*GROUP+2] & p_p0[k*GROUP+1] & g_p0[k*GROUP]);
            gp_p0[k] = &p_p0[k*GROUP +: GROUP];
        end
    end

    // ---- stage 1 registers: a, effective b/carry-in, group G/P, local carries ----
    logic             vld_p1, vld_p2;
    logic [WIDTH-1:0] a_p1, b_p1, lc_p1;
    logic             c_p1;
    logic [NG-1:0]    gg_p1, gp_p1;
    logic             ld1, ld2;

    // A stage loads when it is empty or its content leaves this same cycle.
    assign ld2      = ~vld_p2 | out_ready;
    assign ld1      = ~vld_p1 | ld2;
    assign in_ready = ~rst & ld1;

    // ---- stage 1 -> 2: group carries, final carries, sum and flags ----
    logic [WIDTH-1:0] p_p1, cy_p1, sum_n_p1;
    logic [NG:0]      gc_p1;
    logic             ovf_n_p1;

    always_comb begin
        logic acc;
        logic prod;
        p_p1  = a_p1 ^ b_p1;
        gc_p1 = '0;
        cy_p1 = '0;
        // Each group carry is an independent sum of products over the lower
        // groups' G/P and the carry-in, so there is no chain between groups.
        for (int k = 0; k <= NG; k++) begin
            acc  = 1'b0;
            prod = 1'b1;
            for (int j = k - 1; j >= 0; j--) begin
                acc  = acc | (prod & gg_p1[j]);
                prod = prod & gp_p1[j];
            end
            gc_p1[k] = acc | (prod & c_p1);
        end
        for (int k = 0; k < NG; k++) begin
            prod = 1'b1;
            for (int o = 0; o < GROUP; o++) begin
                cy_p1[k*GROUP+o] = lc_p1[k*GROUP+o] | (prod & gc_p1[k]);
                prod = prod & p_p1[k*GROUP+o];
            end
        end
        sum_n_p1 = p_p1 ^ cy_p1;
        ovf_n_p1 = (a_p1[WIDTH-1] == b_p1[WIDTH-1]) && (sum_n_p1[WIDTH-1] != a_p1[WIDTH-1]);
    end

    // ---- stage 2 registers: sum, cout, ovf, zero ----
    logic [WIDTH-1:0] sum_p2;
    logic             cout_p2, ovf_p2, zero_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            a_p1    <= '0;
            b_p1    <= '0;
            c_p1    <= 1'b0;
            gg_p1   <= '0;
            gp_p1   <= '0;
            lc_p1   <= '0;
            sum_p2  <= '0;
            cout_p2 <= 1'b0;
            ovf_p2  <= 1'b0;
            zero_p2 <= 1'b0;
        end else begin
            if (ld1) begin
                vld_p1 <= in_valid;
            end
            if (ld1 && in_valid) begin
                a_p1  <= a;
                b_p1  <= beff_p0;
                c_p1  <= ceff_p0;
                gg_p1 <= gg_p0;
                gp_p1 <= gp_p0;
                lc_p1 <= lc_p0;
            end
            if (ld2) begin
                vld_p2 <= vld_p1;
            end
            if (ld2 && vld_p1) begin
                sum_p2  <= sum_n_p1;
                cout_p2 <= gc_p1[NG];
                ovf_p2  <= ovf_n_p1;
                zero_p2 <= ~|sum_n_p1;
            end
        end
    end

    assign out_valid = vld_p2;
    assign sum       = sum_p2;
    assign cout      = cout_p2;
    assign ovf       = ovf_p2;
    assign zero      = zero_p2;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Testbench for pipelined_cla_addsub (WIDTH = 16): directed corner vectors,
// backpressure, asynchronous reset mid-flight, random streaming and random
// handshaking, all scored against an arithmetic reference model.
module tb_pipelined_cla_addsub;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready;
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic         out_valid, out_ready;
    logic [W-1:0] sum;
    logic         cout, ovf, zero;

    always #5 clk = ~clk;

    pipelined_cla_addsub #(.WIDTH(W), .GROUP(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        logic         z;
    } res_t;

    res_t exp_q[$];
    int   errors  = 0;
    int   checks  = 0;
    int   emitted = 0;
    bit   mon_en  = 1'b0;
    bit   held    = 1'b0;
    res_t held_val;

    // Reference: plain integer arithmetic on the operands.
    function automatic res_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                   input logic tc, input logic ts);
        res_t         r;
        logic [W:0]   full;
        int           sr;
        if (ts) begin
            full[W-1:0] = ta - tb;
            full[W]     = (ta >= tb);
            sr          = int'($signed(ta)) - int'($signed(tb));
        end else begin
            full = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
            sr   = int'($signed(ta)) + int'($signed(tb)) + (tc ? 1 : 0);
        end
        r.s = full[W-1:0];
        r.c = full[W];
        r.o = (sr > ((1 << (W-1)) - 1)) || (sr < -(1 << (W-1)));
        r.z = (r.s == '0);
        return r;
    endfunction

    task automatic check1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic checkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: handshakes are evaluated mid-cycle, ahead of the edge
    // on which they take effect.
    always @(negedge clk) begin
        res_t e;
        if (mon_en && !rst) begin
            if (held && out_valid) begin
                checkw("hold_sum", sum, held_val.s);
                check1("hold_flags", (cout == held_val.c) && (ovf == held_val.o) && (zero == held_val.z), 1'b1);
            end
            if (out_valid && out_ready) begin
                emitted++;
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_result: got sum=%h with none outstanding at %0t", sum, $time);
                end else begin
                    e = exp_q.pop_front();
                    checkw("model_sum", sum, e.s);
                    check1("model_cout", cout, e.c);
                    check1("model_ovf", ovf, e.o);
                    check1("model_zero", zero, e.z);
                end
            end
            held     = out_valid && !out_ready;
            held_val = '{s: sum, c: cout, o: ovf, z: zero};
            if (in_valid && in_ready)
                exp_q.push_back(model(a, b, cin, sub));
        end else begin
            held = 1'b0;
        end
    end

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    task automatic set_rand(input logic v);
        a        = rnd_op();
        b        = rnd_op();
        cin      = 1'($urandom_range(0, 1));
        sub      = 1'($urandom_range(0, 1));
        in_valid = v;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic drive_beat(input logic [W-1:0] ta, input logic [W-1:0] tb,
                              input logic tc, input logic ts);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) begin
            errors++;
            checks++;
            $display("FAIL accept_timeout: got no in_ready within %0d cycles, required acceptance", n);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check_int("drain_outstanding", exp_q.size(), 0);
    endtask

    // One beat on an idle pipeline, with literal expected outputs and exact latency.
    task automatic directed(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                            input logic tc, input logic ts, input logic [W-1:0] es,
                            input logic ec, input logic eo, input logic ez);
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
        @(negedge clk);
        check1({nm, "_in_ready"}, in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check1({nm, "_early_valid"}, out_valid, 1'b0);
        @(posedge clk); #1;
        check1({nm, "_out_valid"}, out_valid, 1'b1);
        checkw({nm, "_sum"}, sum, es);
        check1({nm, "_cout"}, cout, ec);
        check1({nm, "_ovf"}, ovf, eo);
        check1({nm, "_zero"}, zero, ez);
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check1("rst_out_valid", out_valid, 1'b0);
        checkw("rst_sum", sum, '0);
        check1("rst_flags", cout | ovf | zero, 1'b0);
        check1("rst_in_ready", in_ready, 1'b0);
        #1 rst = 1'b0;
        #1 check1("rel_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Directed vectors with hand-computed results
        directed("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        directed("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        directed("add_cin",   16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0);
        directed("sub_borrow",16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        directed("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        directed("sub_zero",  16'hA5A5, 16'hA5A5, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

        // Backpressure: out_ready low for 4 cycles around 3 back-to-back beats
        e0 = emitted;
        out_ready = 1'b0;
        fork
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join_none
        drive_beat(16'h0101, 16'h0202, 1'b0, 1'b0);
        drive_beat(16'h1000, 16'h0001, 1'b0, 1'b1);
        a = 16'h7FFF; b = 16'h7FFF; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        check1("bp_in_ready_low", in_ready, 1'b0);
        @(posedge clk); #1;
        drive_beat(16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
        wait_drain();
        check_int("bp_emitted", emitted - e0, 3);

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        drive_beat(16'h1111, 16'h2222, 1'b0, 1'b0);
        drive_beat(16'h0F0F, 16'h0101, 1'b1, 1'b0);
        check1("rstmid_full", out_valid, 1'b1);
        #2;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check1("rstmid_out_valid", out_valid, 1'b0);
        checkw("rstmid_sum", sum, '0);
        check1("rstmid_in_ready", in_ready, 1'b0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        #1 check1("rstmid_rel_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check1("rstmid_no_stale", out_valid, 1'b0);
        end
        @(posedge clk); #1;

        // Full-rate streaming
        e0 = emitted;
        for (int i = 0; i < 1000; i++) begin
            set_rand(1'b1);
            @(negedge clk);
            if (i >= 2) check1("stream_out_valid", out_valid, 1'b1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_drain();
        check_int("stream_emitted", emitted - e0, 1000);

        // Random handshaking on both sides
        for (int i = 0; i < 400; i++) begin
            set_rand(1'($urandom_range(0, 1)));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
